bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
Parametrised multi-digit BCD counter with up/down counting, programmable modulus, synchronous clear, parallel load with validity checking, and cascade outputs. It is the general-purpose successor to the fixed two-digit mod-100 counter. It drives BCD display digits and timebase chains (seconds/minutes/hours), and is built for chaining via tc.

Parameters:
DIGITS, 2, number of BCD digits; count width is 4*DIGITS bits; legal range 1..8.
MODULUS, 100, count sequence length; legal range 2..10^DIGITS; counter spans 0..MODULUS-1.

Ports:
clk  input  1  rising-edge clock
rstb  input  1  asynchronous active-low reset
clr  input  1  synchronous clear to 0, highest synchronous priority
load  input  1  synchronous parallel load request
load_val  input  4*DIGITS  packed BCD load value; digit 0 in bits [3:0]
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
count  output  4*DIGITS  packed BCD count value; digit 0 least significant
tc  output  1  combinational terminal count: en & (count at terminal value for current direction)
wrap  output  1  registered one-cycle pulse following a wrap transition
load_err  output  1  registered one-cycle pulse following a rejected load

Behaviour:
- Reset: rstb low asynchronously forces count=0, wrap=0, load_err=0. These values hold while rstb is low. Counting resumes on the first clk edge after rstb deasserts. Reset mid-count discards all state.
- Synchronous priority per clock edge: clr > load > en. Lower-priority requests in the same cycle are ignored, with no effect and no error.
- clr=1: count <= 0; wrap <= 0; load_err <= 0.
- load=1 (clr=0): the load is accepted only if every digit of load_val is <= 9 and the value is < MODULUS.
  - Accepted: count <= load_val; load_err <= 0.
  - Rejected: count unchanged; load_err <= 1 for exactly one cycle.
  - wrap <= 0 in both cases.
- en=1, up_dn=1 (no clr/load):
  - Digit 0 increments.
  - A digit at 9 rolls to 0 and carries into the next digit; the carry ripples within the same cycle.
  - If count == MODULUS-1: count <= 0 and wrap <= 1.
- en=1, up_dn=0:
  - Digit 0 decrements.
  - A digit at 0 rolls to 9 and borrows from the next digit.
  - If count == 0: count <= MODULUS-1 (BCD encoded) and wrap <= 1.
- en=0 (no clr/load): count holds; wrap <= 0; load_err <= 0.
- wrap and load_err are single-cycle pulses. Consecutive wraps on back-to-back cycles (MODULUS=2) produce wrap high on consecutive cycles.
- tc is purely combinational and has no latency:
  - up_dn=1: tc = en & (count == MODULUS-1).
  - up_dn=0: tc = en & (count == 0).
  - For cascading, connect tc of a stage to en of the next stage; the next stage steps on the same edge the lower stage wraps.
- Direction change: up_dn is sampled each edge. Reversing at a terminal value counts normally with no wrap (e.g. count=0, up_dn=1 -> 1).
- Invariant: count never holds a non-BCD digit or a value >= MODULUS after reset, in any reachable state.
- MODULUS-1 BCD encoding is a constant computed at elaboration.
- Out-of-range parameters are an elaboration error (generate-time check).
- Arithmetic is per-digit 4-bit with a 1-bit carry/borrow chain. No binary-to-BCD conversion is used.

Test Plan:
- Default params, rstb pulse, then en=1, up_dn=1 for 100 cycles -> count steps 00..99 then 00; wrap high exactly one cycle after the 99->00 edge; tc high only while count=0x99.
- Default params, count=0x00, en=1, up_dn=0 -> next 0x99 with wrap pulse; then 0x98, 0x97; tc high only at 0x00.
- DIGITS=2, MODULUS=60: load 0x58, count up -> 0x59, 0x00 with wrap. load 0x60 -> rejected, count holds, load_err one cycle. load 0x3A -> rejected.
- DIGITS=3, MODULUS=1000: load 0x199, up -> 0x200. load 0x300, down -> 0x299 (multi-digit ripple carry/borrow).
- Priority: clr=1, load=1 (0x45), en=1 at count 0x12 -> count 0x00. Next cycle load=1 (0x45), en=1 -> count 0x45, no increment.
- Assert rstb low mid-count at 0x73 between edges -> count 0x00 immediately (async). Release, en=1 -> 0x01 on first edge.

Source files
------------

// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle for the multi-digit BCD up/down counter.
interface bcd_updown_counter_if #(
  parameter int unsigned DIGITS = 2
);

  localparam int unsigned W = 4 * DIGITS;

  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         up_dn;
  logic [W-1:0] count;
  logic         tc;
  logic         wrap;
  logic         load_err;

  // Controller side: issues commands, observes count and pulses.
  modport master (
    output clr,
    output load,
    output load_val,
    output en,
    output up_dn,
    input  count,
    input  tc,
    input  wrap,
    input  load_err
  );

  // Counter side.
  modport slave (
    input  clr,
    input  load,
    input  load_val,
    input  en,
    input  up_dn,
    output count,
    output tc,
    output wrap,
    output load_err
  );

endinterface

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with programmable modulus,
// synchronous clear, validated parallel load and cascade terminal count.
module bcd_updown_counter #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 100
) (
  input  logic                 clk,
  input  logic                 rstb,
  bcd_updown_counter_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  // 10^n, used only to bound MODULUS at elaboration.
  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

  // Elaboration-time BCD encoding of a constant.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  rem;
    r   = '0;
    rem = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  localparam int unsigned  MOD_LIMIT = pow10(DIGITS);
  localparam logic [W-1:0] MAX_BCD   = to_bcd(MODULUS - 1);

  // Reject illegal parameterisations at elaboration.
  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("bcd_updown_counter: DIGITS=%0d outside 1..8", DIGITS);
  end
  if (MODULUS < 2 || MODULUS > MOD_LIMIT) begin : g_bad_modulus
    $error("bcd_updown_counter: MODULUS=%0d outside 2..10^DIGITS", MODULUS);
  end

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         wrap_q;
  logic         wrap_d;
  logic         err_q;
  logic         err_d;
  logic [W-1:0] inc_val;
  logic [W-1:0] dec_val;
  logic         load_ok;
  logic         at_max;
  logic         at_zero;

  assign at_max  = (count_q == MAX_BCD);
  assign at_zero = (count_q == '0);

  // Per-digit increment with a ripple carry; a 9 rolls to 0 and carries on.
  always_comb begin : p_incr
    logic carry;
    carry   = 1'b1;
    inc_val = count_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

  // Per-digit decrement with a ripple borrow; a 0 rolls to 9 and borrows on.
  always_comb begin : p_decr
    logic borrow;
    borrow  = 1'b1;
    dec_val = count_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // A load is legal only when every digit is BCD and the value is in range;
  // with all digits valid, BCD ordering matches numeric ordering.
  always_comb begin : p_load_check
    load_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
    if (bus.load_val > MAX_BCD) begin
      load_ok = 1'b0;
    end
  end

  // Next-state selection with clr > load > en priority.
  always_comb begin : p_next
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      if (load_ok) begin
        count_d = bus.load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (at_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (at_zero) begin
          count_d = MAX_BCD;
          wrap_d  = 1'b1;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge rstb) begin : p_regs
    if (!rstb) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = err_q;
  // Terminal count has no latency so the next stage steps on the wrap edge.
  assign bus.tc       = bus.en & (bus.up_dn ? at_max : at_zero);

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: four counter configurations driven in lockstep and
// compared against an integer-arithmetic reference model.
module tb_bcd_updown_counter;

  localparam int unsigned N = 4;
  localparam int unsigned MODS [N] = '{100, 60, 1000, 2};
  localparam int unsigned DGS  [N] = '{2, 2, 3, 1};

  logic clk;
  logic rstb;

  bcd_updown_counter_if #(.DIGITS(2)) b0 ();
  bcd_updown_counter_if #(.DIGITS(2)) b1 ();
  bcd_updown_counter_if #(.DIGITS(3)) b2 ();
  bcd_updown_counter_if #(.DIGITS(1)) b3 ();

  bcd_updown_counter #(.DIGITS(2), .MODULUS(100))  dut0 (.clk(clk), .rstb(rstb), .bus(b0));
  bcd_updown_counter #(.DIGITS(2), .MODULUS(60))   dut1 (.clk(clk), .rstb(rstb), .bus(b1));
  bcd_updown_counter #(.DIGITS(3), .MODULUS(1000)) dut2 (.clk(clk), .rstb(rstb), .bus(b2));
  bcd_updown_counter #(.DIGITS(1), .MODULUS(2))    dut3 (.clk(clk), .rstb(rstb), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] act_count [N];
  logic [N-1:0] act_tc;
  logic [N-1:0] act_wrap;
  logic [N-1:0] act_err;

  assign act_count[0] = 32'(b0.count);
  assign act_count[1] = 32'(b1.count);
  assign act_count[2] = 32'(b2.count);
  assign act_count[3] = 32'(b3.count);
  assign act_tc   = {b3.tc, b2.tc, b1.tc, b0.tc};
  assign act_wrap = {b3.wrap, b2.wrap, b1.wrap, b0.wrap};
  assign act_err  = {b3.load_err, b2.load_err, b1.load_err, b0.load_err};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: counter value as a plain integer.
  int unsigned mv [N];
  bit          mw [N];
  bit          me [N];

  typedef struct {
    logic        clr;
    logic        load;
    logic [31:0] lv;
    logic        en;
    logic        up;
    logic [31:0] exp0;
    logic        wrap0;
    logic        err0;
    logic [31:0] exp1;
    logic        wrap1;
    logic        err1;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [31:0] to_bcd_tb(input int unsigned v, input int unsigned d);
    logic [31:0] r;
    int unsigned rem;
    r   = '0;
    rem = v;
    for (int unsigned k = 0; k < d; k++) begin
      r   = r | (32'(rem % 10) << (4 * k));
      rem = rem / 10;
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) begin
      mv[i] = 0;
      mw[i] = 1'b0;
      me[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic c, input logic l, input logic [31:0] lv,
                            input logic e, input logic u);
    for (int i = 0; i < int'(N); i++) begin
      int unsigned d;
      int unsigned m;
      int unsigned val;
      int unsigned nib;
      bit          ok;
      d   = DGS[i];
      m   = MODS[i];
      ok  = 1'b1;
      val = 0;
      for (int k = int'(d) - 1; k >= 0; k--) begin
        nib = (lv >> (4 * k)) & 32'hF;
        if (nib > 9) ok = 1'b0;
        val = val * 10 + nib;
      end
      mw[i] = 1'b0;
      me[i] = 1'b0;
      if (c) begin
        mv[i] = 0;
      end else if (l) begin
        if (ok && val < m) mv[i] = val;
        else me[i] = 1'b1;
      end else if (e) begin
        if (u) begin
          if (mv[i] == m - 1) begin mv[i] = 0; mw[i] = 1'b1; end
          else mv[i] = mv[i] + 1;
        end else begin
          if (mv[i] == 0) begin mv[i] = m - 1; mw[i] = 1'b1; end
          else mv[i] = mv[i] - 1;
        end
      end
    end
  endtask

  task automatic drive(input logic c, input logic l, input logic [31:0] lv,
                       input logic e, input logic u);
    b0.clr = c; b0.load = l; b0.load_val = 8'(lv);  b0.en = e; b0.up_dn = u;
    b1.clr = c; b1.load = l; b1.load_val = 8'(lv);  b1.en = e; b1.up_dn = u;
    b2.clr = c; b2.load = l; b2.load_val = 12'(lv); b2.en = e; b2.up_dn = u;
    b3.clr = c; b3.load = l; b3.load_val = 4'(lv);  b3.en = e; b3.up_dn = u;
  endtask

  task automatic check_outputs();
    for (int i = 0; i < int'(N); i++) begin
      check($sformatf("count[%0d]", i), act_count[i], to_bcd_tb(mv[i], DGS[i]));
      check($sformatf("wrap[%0d]", i), 32'(act_wrap[i]), 32'(mw[i]));
      check($sformatf("load_err[%0d]", i), 32'(act_err[i]), 32'(me[i]));
    end
  endtask

  // One clocked step: apply inputs, check tc before the edge, outputs after.
  task automatic cycle(input logic c, input logic l, input logic [31:0] lv,
                       input logic e, input logic u);
    drive(c, l, lv, e, u);
    #1;
    for (int i = 0; i < int'(N); i++) begin
      bit etc;
      etc = e & (u ? (mv[i] == MODS[i] - 1) : (mv[i] == 0));
      check($sformatf("tc[%0d]", i), 32'(act_tc[i]), 32'(etc));
    end
    @(posedge clk);
    model_step(c, l, lv, e, u);
    #1;
    check_outputs();
  endtask

  initial begin
    int          wraps;
    logic [31:0] rlv;

    vecs[0]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h99, 1'b1, 1'b0, 32'h59, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h98, 1'b0, 1'b0, 32'h58, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h97, 1'b0, 1'b0, 32'h57, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h58, 1'b0, 1'b0, 32'h58, 1'b0, 1'b0, 32'h58, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h59, 1'b0, 1'b0, 32'h59, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h60, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h60, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h3A, 1'b0, 1'b1, 32'h60, 1'b0, 1'b1, 32'h00, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 32'h45, 1'b1, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h45, 1'b1, 1'b1, 32'h45, 1'b0, 1'b0, 32'h45, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h46, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h45, 1'b0, 1'b0, 32'h45, 1'b0, 1'b0};

    // Reset state.
    rstb = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors from reset.
    for (int v = 0; v < 13; v++) begin
      cycle(vecs[v].clr, vecs[v].load, vecs[v].lv, vecs[v].en, vecs[v].up);
      check($sformatf("vec%0d count0", v), act_count[0], vecs[v].exp0);
      check($sformatf("vec%0d wrap0", v), 32'(act_wrap[0]), 32'(vecs[v].wrap0));
      check($sformatf("vec%0d err0", v), 32'(act_err[0]), 32'(vecs[v].err0));
      check($sformatf("vec%0d count1", v), act_count[1], vecs[v].exp1);
      check($sformatf("vec%0d wrap1", v), 32'(act_wrap[1]), 32'(vecs[v].wrap1));
      check($sformatf("vec%0d err1", v), 32'(act_err[1]), 32'(vecs[v].err1));
    end

    // Three-digit ripple carry and borrow.
    cycle(1'b0, 1'b1, 32'h199, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("ripple_up", act_count[2], 32'h200);
    cycle(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("ripple_down", act_count[2], 32'h299);

    // Full mod-100 up sweep: exactly one wrap, landing back on 00.
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    wraps = 0;
    for (int k = 0; k < 100; k++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (act_wrap[0]) wraps++;
      if (k == 98) check("sweep_at_99", act_count[0], 32'h99);
    end
    check("sweep_wraps", 32'(wraps), 32'd1);
    check("sweep_end", act_count[0], 32'h00);
    check("sweep_wrap_last", 32'(act_wrap[0]), 32'd1);

    // MODULUS=2 back-to-back wraps (up from 1, then down from 0).
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("m2_step", act_count[3], 32'h1);
    check("m2_nowrap", 32'(act_wrap[3]), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("m2_wrap_a", 32'(act_wrap[3]), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("m2_wrap_b", 32'(act_wrap[3]), 32'd1);
    check("m2_val", act_count[3], 32'h1);

    // Asynchronous reset between edges, hold, then resume.
    cycle(1'b0, 1'b1, 32'h73, 1'b0, 1'b1);
    check("pre_reset", act_count[0], 32'h73);
    #2;
    rstb = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    model_reset();
    check("async_reset", act_count[0], 32'h00);
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rstb = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    check("post_reset", act_count[0], 32'h01);

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(1)) begin
        rlv = {20'h0, 4'($urandom_range(9)), 4'($urandom_range(9)), 4'($urandom_range(9))};
      end else begin
        rlv = $urandom;
      end
      cycle(($urandom_range(31) == 0), ($urandom_range(7) == 0), rlv,
            ($urandom_range(3) != 0), 1'($urandom_range(1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
